// File: rtl/wbmem_pkg.sv
// Shared types and sizing helpers for the multi-channel image/weight stream buffer.
package wbmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_WGT = 2'b01;
  localparam logic [1:0] SEL_IMG = 2'b10;

  function automatic int img_depth(input int ch, input int w, input int h);
    return ch * w * h;
  endfunction

  function automatic int wgt_depth(input int ch, input int k);
    return ch * k * k;
  endfunction

  // Address width for an array of the given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wbmem_stream_if.sv
// Load-stream and output-stream bundle between host loader, buffer and MAC array.
interface wbmem_stream_if #(
  parameter int DW    = 8,
  parameter int IMG_W = 36,
  parameter int IMG_H = 36
);
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [1:0]    load_sel;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pix;
  logic [DW-1:0] out_wgt;
  logic          out_first;
  logic          out_last_win;
  logic          out_last;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;

  modport master (
    output load_sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_pix, out_wgt, out_first, out_last_win,
           out_last, out_row, out_col
  );

  modport slave (
    input  load_sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_pix, out_wgt, out_first, out_last_win,
           out_last, out_row, out_col
  );
endinterface

// File: rtl/wbmem_sp_ram.sv
// Simple-dual-port RAM: one write port, one registered read port, array not reset.
module wbmem_sp_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_r [DEPTH];

  // Write on request; read address is re-sampled every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end
endmodule

// File: rtl/wbmem_stream.sv
// Multi-channel image/weight buffer: loads planes and kernels, then walks every valid
// convolution window streaming (pixel, weight) pairs with framing flags.
module wbmem_stream
  import wbmem_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 36,
  parameter int IMG_H = 36,
  parameter int CH    = 3,
  parameter int K     = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           img_loaded,
  output logic           wgt_loaded,
  wbmem_stream_if.slave  bus
);
  localparam int IMG_DEPTH = img_depth(CH, IMG_W, IMG_H);
  localparam int WGT_DEPTH = wgt_depth(CH, K);
  localparam int IAW = addr_w(IMG_DEPTH);
  localparam int WAW = addr_w(WGT_DEPTH);
  localparam int KW  = addr_w(K);
  localparam int CHW = addr_w(CH);
  localparam int RW  = addr_w(IMG_H);
  localparam int CW  = addr_w(IMG_W);

  state_e         state_r, state_nx;
  logic [IAW-1:0] img_ptr_r;
  logic [WAW-1:0] wgt_ptr_r;
  logic           img_loaded_r, wgt_loaded_r;
  logic [KW-1:0]  kx_r, ky_r;
  logic [CHW-1:0] ch_r;
  logic [CW-1:0]  ocol_r;
  logic [RW-1:0]  orow_r;

  logic           in_ready_s, load_acc_s, start_acc_s, beat_acc_s, emit_s;
  logic           img_we_s, wgt_we_s;
  logic           kx_max_s, ky_max_s, ch_max_s, ocol_max_s, orow_max_s;
  logic           first_s, last_win_s, last_s;
  logic [IAW-1:0] pix_addr_s;
  logic [WAW-1:0] wgt_addr_s;
  logic [DW-1:0]  pix_rd_s, wgt_rd_s;

  assign in_ready_s  = (state_r == ST_IDLE) && !start &&
                       ((bus.load_sel == SEL_WGT) || (bus.load_sel == SEL_IMG));
  assign load_acc_s  = bus.in_valid && in_ready_s;
  assign start_acc_s = (state_r == ST_IDLE) && start && img_loaded_r && wgt_loaded_r;
  assign emit_s      = (state_r == ST_EMIT);
  assign beat_acc_s  = emit_s && bus.out_ready;
  assign img_we_s    = load_acc_s && (bus.load_sel == SEL_IMG);
  assign wgt_we_s    = load_acc_s && (bus.load_sel == SEL_WGT);

  // Window decode and RAM read addresses, all derived from the registered counters.
  always_comb begin
    kx_max_s   = (kx_r == KW'(K - 1));
    ky_max_s   = (ky_r == KW'(K - 1));
    ch_max_s   = (ch_r == CHW'(CH - 1));
    ocol_max_s = (ocol_r == CW'(IMG_W - K));
    orow_max_s = (orow_r == RW'(IMG_H - K));
    first_s    = (kx_r == KW'(0)) && (ky_r == KW'(0)) && (ch_r == CHW'(0));
    last_win_s = kx_max_s && ky_max_s && ch_max_s;
    last_s     = last_win_s && ocol_max_s && orow_max_s;
    pix_addr_s = IAW'(int'(ch_r) * IMG_W * IMG_H
                      + (int'(orow_r) + int'(ky_r)) * IMG_W
                      + int'(ocol_r) + int'(kx_r));
    wgt_addr_s = WAW'(int'(ch_r) * K * K + int'(ky_r) * K + int'(kx_r));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next state: FETCH always lasts one cycle so the registered read lands in EMIT.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE:  if (start_acc_s) state_nx = ST_FETCH; else state_nx = ST_IDLE;
      ST_FETCH: state_nx = ST_EMIT;
      ST_EMIT: begin
        if (bus.out_ready) begin
          if (last_s) state_nx = ST_DONE; else state_nx = ST_FETCH;
        end else begin
          state_nx = ST_EMIT;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Load pointers wrap at the last address and latch the sticky loaded flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_ptr_r    <= {IAW{1'b0}};
      wgt_ptr_r    <= {WAW{1'b0}};
      img_loaded_r <= 1'b0;
      wgt_loaded_r <= 1'b0;
    end else if (start_acc_s) begin
      img_ptr_r <= {IAW{1'b0}};
      wgt_ptr_r <= {WAW{1'b0}};
    end else if (img_we_s) begin
      if (img_ptr_r == IAW'(IMG_DEPTH - 1)) begin
        img_ptr_r    <= {IAW{1'b0}};
        img_loaded_r <= 1'b1;
      end else begin
        img_ptr_r <= img_ptr_r + IAW'(1);
      end
    end else if (wgt_we_s) begin
      if (wgt_ptr_r == WAW'(WGT_DEPTH - 1)) begin
        wgt_ptr_r    <= {WAW{1'b0}};
        wgt_loaded_r <= 1'b1;
      end else begin
        wgt_ptr_r <= wgt_ptr_r + WAW'(1);
      end
    end
  end

  // Window walk, fastest first: kx, ky, ch, ocol, orow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || start_acc_s) begin
      kx_r   <= {KW{1'b0}};
      ky_r   <= {KW{1'b0}};
      ch_r   <= {CHW{1'b0}};
      ocol_r <= {CW{1'b0}};
      orow_r <= {RW{1'b0}};
    end else if (beat_acc_s) begin
      if (!kx_max_s) begin
        kx_r <= kx_r + KW'(1);
      end else begin
        kx_r <= {KW{1'b0}};
        if (!ky_max_s) begin
          ky_r <= ky_r + KW'(1);
        end else begin
          ky_r <= {KW{1'b0}};
          if (!ch_max_s) begin
            ch_r <= ch_r + CHW'(1);
          end else begin
            ch_r <= {CHW{1'b0}};
            if (!ocol_max_s) begin
              ocol_r <= ocol_r + CW'(1);
            end else begin
              ocol_r <= {CW{1'b0}};
              if (!orow_max_s) orow_r <= orow_r + RW'(1);
              else             orow_r <= {RW{1'b0}};
            end
          end
        end
      end
    end
  end

  wbmem_sp_ram #(.DW(DW), .DEPTH(IMG_DEPTH), .AW(IAW)) u_img_ram (
    .clk(clk), .we(img_we_s), .waddr(img_ptr_r), .wdata(bus.in_data),
    .raddr(pix_addr_s), .rdata(pix_rd_s)
  );

  wbmem_sp_ram #(.DW(DW), .DEPTH(WGT_DEPTH), .AW(WAW)) u_wgt_ram (
    .clk(clk), .we(wgt_we_s), .waddr(wgt_ptr_r), .wdata(bus.in_data),
    .raddr(wgt_addr_s), .rdata(wgt_rd_s)
  );

  // Beat outputs are forced to zero outside EMIT so reset and idle present a clean bus.
  assign busy             = (state_r == ST_FETCH) || emit_s;
  assign done             = (state_r == ST_DONE);
  assign img_loaded       = img_loaded_r;
  assign wgt_loaded       = wgt_loaded_r;
  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = emit_s;
  assign bus.out_pix      = emit_s ? pix_rd_s : {DW{1'b0}};
  assign bus.out_wgt      = emit_s ? wgt_rd_s : {DW{1'b0}};
  assign bus.out_first    = emit_s && first_s;
  assign bus.out_last_win = emit_s && last_win_s;
  assign bus.out_last     = emit_s && last_s;
  assign bus.out_row      = emit_s ? orow_r : {RW{1'b0}};
  assign bus.out_col      = emit_s ? ocol_r : {CW{1'b0}};
endmodule

// File: tb/tb_wbmem_stream.sv
// Randomized-stall bench for wbmem_stream against a loop-based window-walk model.
module tb_wbmem_stream;
  import wbmem_pkg::*;

  localparam int DW = 8, IW = 4, IH = 4, CH = 2, K = 3;
  localparam int NIMG = CH * IW * IH;
  localparam int NWGT = CH * K * K;
  localparam int NB   = (IH - K + 1) * (IW - K + 1) * CH * K * K;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, img_loaded, wgt_loaded;

  wbmem_stream_if #(.DW(DW), .IMG_W(IW), .IMG_H(IH)) bus ();

  wbmem_stream #(.DW(DW), .IMG_W(IW), .IMG_H(IH), .CH(CH), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .img_loaded(img_loaded), .wgt_loaded(wgt_loaded), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0]  img_m [NIMG];
  logic [7:0]  wgt_m [NWGT];
  logic [22:0] exp_beat [NB];
  logic [22:0] cap_beat [NB];
  int beat_idx = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  bit stall_mode = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected frame straight from the window definition.
  task automatic build_model();
    int n = 0;
    for (int orow = 0; orow <= IH - K; orow++)
      for (int ocol = 0; ocol <= IW - K; ocol++)
        for (int c = 0; c < CH; c++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
              logic f, lw, l;
              f  = (c == 0) && (ky == 0) && (kx == 0);
              lw = (c == CH - 1) && (ky == K - 1) && (kx == K - 1);
              l  = lw && (orow == IH - K) && (ocol == IW - K);
              exp_beat[n] = {img_m[c * IW * IH + (orow + ky) * IW + ocol + kx],
                             wgt_m[c * K * K + ky * K + kx], f, lw, l,
                             2'(orow), 2'(ocol)};
              n++;
            end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every valid cycle must show the model beat at the current index.
  always @(negedge clk) begin
    if (rst && done) done_cnt++;
    if (chk_en && rst && bus.out_valid) begin
      if (beat_idx >= NB) begin
        chk("beat_overrun", 32'(beat_idx), 32'(NB - 1));
      end else begin
        cap_beat[beat_idx] = {bus.out_pix, bus.out_wgt, bus.out_first, bus.out_last_win,
                              bus.out_last, bus.out_row, bus.out_col};
        chk($sformatf("beat%0d", beat_idx), 32'(cap_beat[beat_idx]), 32'(exp_beat[beat_idx]));
        if (bus.out_ready) beat_idx++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.load_sel = 2'b00;
    bus.in_data = 8'h00;
    tick(3);
    chk("reset_state", 32'({busy, done, img_loaded, wgt_loaded, bus.out_valid, bus.in_ready}), 32'd0);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic send_beat(input logic [1:0] sel, input logic [7:0] d);
    int t = 0;
    bus.load_sel = sel;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    #1;
    while (!bus.in_ready && t < 20) begin
      tick(1);
      t++;
    end
    if (t >= 20) chk("load_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_img(input bit fresh);
    for (int i = 0; i < NIMG; i++) begin
      send_beat(SEL_IMG, 8'(i));
      img_m[i] = 8'(i);
      if (fresh && i == NIMG - 2) chk("img_loaded_early", 32'(img_loaded), 32'd0);
      if (i == NIMG - 1) chk("img_loaded_set", 32'(img_loaded), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.load_sel = 2'b00;
  endtask

  task automatic load_wgt(input bit fresh);
    for (int i = 0; i < NWGT; i++) begin
      send_beat(SEL_WGT, 8'(100 + i));
      wgt_m[i] = 8'(100 + i);
      if (fresh && i == NWGT - 2) chk("wgt_loaded_early", 32'(wgt_loaded), 32'd0);
      if (i == NWGT - 1) chk("wgt_loaded_set", 32'(wgt_loaded), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.load_sel = 2'b00;
  endtask

  task automatic run_frame(input bit stall, input bit poke_load);
    int cyc = 0;
    bit ready_busy = 1'b0;
    build_model();
    stall_mode = stall;
    beat_idx = 0;
    done_cnt = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk_en = 1'b1;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (poke_load) begin
      bus.load_sel = SEL_IMG;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h55;
    end
    while (!done && cyc < 4000) begin
      if (busy && bus.in_ready) ready_busy = 1'b1;
      tick(1);
      cyc++;
    end
    chk("frame_done_seen", 32'(done), 32'd1);
    if (!stall) chk("frame_cycles", 32'(cyc), 32'(2 * NB));
    bus.in_valid = 1'b0;
    bus.load_sel = 2'b00;
    tick(2);
    chk_en = 1'b0;
    stall_mode = 1'b0;
    chk("beat_total", 32'(beat_idx), 32'(NB));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("idle_after_done", 32'({busy, done, bus.out_valid}), 32'd0);
    if (poke_load) chk("in_ready_low_busy", 32'(ready_busy), 32'd0);
  endtask

  initial begin
    int t;
    bit seen_valid;

    // Load both sets and stream with out_ready held high.
    do_reset();
    load_img(1'b1);
    load_wgt(1'b1);
    build_model();
    chk("model_b8_pix", 32'(exp_beat[8][22:15]), 32'd10);
    chk("model_b71_flags", 32'(exp_beat[71][6:0]), 32'b0110101);
    run_frame(1'b0, 1'b0);
    chk("beat0", 32'(cap_beat[0]),  32'({8'd0,  8'd100, 3'b100, 2'd0, 2'd0}));
    chk("beat8", 32'(cap_beat[8]),  32'({8'd10, 8'd108, 3'b000, 2'd0, 2'd0}));
    chk("beat17", 32'(cap_beat[17]), 32'({8'd26, 8'd117, 3'b010, 2'd0, 2'd0}));
    chk("beat71", 32'(cap_beat[71]), 32'({8'd31, 8'd117, 3'b011, 2'd1, 2'd1}));

    // Random downstream stalls.
    run_frame(1'b1, 1'b0);

    // start with only the image loaded is ignored.
    do_reset();
    load_img(1'b1);
    start = 1'b1;
    bus.load_sel = SEL_WGT;
    bus.in_valid = 1'b1;
    #1;
    chk("in_ready_blocked_by_start", 32'(bus.in_ready), 32'd0);
    tick(1);
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.load_sel = 2'b00;
    chk("start_ignored_busy", 32'(busy), 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) seen_valid = 1'b1;
      tick(1);
    end
    chk("start_ignored_valid", 32'(seen_valid), 32'd0);
    load_wgt(1'b1);
    run_frame(1'b0, 1'b0);

    // Overwrite image address 0 and poke the load port during the frame.
    send_beat(SEL_IMG, 8'hAA);
    img_m[0] = 8'hAA;
    bus.in_valid = 1'b0;
    bus.load_sel = 2'b00;
    chk("img_loaded_sticky", 32'(img_loaded), 32'd1);
    run_frame(1'b1, 1'b1);
    chk("overwrite_pix0", 32'(cap_beat[0][22:15]), 32'hAA);
    run_frame(1'b0, 1'b0);

    // Reset in the middle of a frame.
    build_model();
    stall_mode = 1'b0;
    beat_idx = 0;
    done_cnt = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk_en = 1'b1;
    t = 0;
    while (beat_idx < 40 && t < 1000) begin
      tick(1);
      t++;
    end
    chk("reach_beat40", 32'(beat_idx), 32'd40);
    chk_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("reset_mid_outputs", 32'({busy, done, img_loaded, wgt_loaded, bus.out_valid,
        bus.out_first, bus.out_last_win, bus.out_last, bus.out_row, bus.out_col}), 32'd0);
    chk("reset_mid_data", 32'({bus.out_pix, bus.out_wgt}), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(5);
    chk("no_done_after_reset", 32'(done_cnt), 32'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_ignored_after_reset", 32'(busy), 32'd0);
    load_img(1'b1);
    load_wgt(1'b1);
    run_frame(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wbmem_stream.md
Name: wbmem_stream

Overview:
Parametrised, multi-channel successor to the single-channel image/weight buffer. Accepts CH image planes and CH×K×K weights over a valid/ready load stream into internal RAM. On start, a window-walk FSM visits every valid convolution position and streams (pixel, weight) pairs with framing flags to the downstream MAC over valid/ready. Sits between the host loader and the multiprecision MAC array.

Parameters:
DW, 8, pixel/weight data width
IMG_W, 36, image width in pixels
IMG_H, 36, image height in pixels
CH, 3, channel count
K, 5, square kernel size (K <= IMG_W, K <= IMG_H)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
load_sel  in  2  00 idle, 01 weights, 10 image, 11 idle
in_valid  in  1  load beat valid
in_data  in  DW  load beat data
in_ready  out  1  load beat accepted when in_valid&in_ready
start  in  1  request to stream a frame
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the final beat handshake
img_loaded  out  1  full image set written since last reset
wgt_loaded  out  1  full weight set written since last reset
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_pix  out  DW  pixel
out_wgt  out  DW  matching weight
out_first  out  1  first beat of a window
out_last_win  out  1  last beat of a window
out_last  out  1  last beat of the frame
out_row  out  clog2(IMG_H)  output row of the current window
out_col  out  clog2(IMG_W)  output column of the current window

Behaviour:
- Reset (async, rst=0): FSM to IDLE; all outputs 0; load pointers, window counters, loaded flags cleared. RAM contents are not cleared. Reset mid-stream abandons the frame with no done pulse.
- Load order: image is channel-major, then row-major (addr = ch*IMG_W*IMG_H + y*IMG_W + x). Weights use addr = ch*K*K + ky*K + kx.
- in_ready = (state==IDLE) & (load_sel==01 | load_sel==10) & !start.
- Each accepted beat writes the pointer selected by load_sel and increments that pointer.
- Pointer wrap: at its last address (CH*IMG_W*IMG_H-1 or CH*K*K-1) the pointer returns to 0 and the matching loaded flag is set. The flag is sticky; further beats overwrite from address 0.
- start is accepted only in IDLE with img_loaded & wgt_loaded. Otherwise it is ignored with no other effect.
- On start acceptance: busy=1, both load pointers reset to 0, window counters cleared, go to FETCH.
- FSM states:
  - IDLE: loading permitted.
  - FETCH: registered RAM addresses issued; always exits to EMIT after 1 cycle.
  - EMIT: out_valid=1; out_pix, out_wgt and flags held stable until out_ready. On handshake, counters advance, then go to FETCH, or to DONE after the final beat.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Throughput: one beat per 2 cycles with out_ready held high. Stalls extend EMIT indefinitely with no data change.
- Counter order, fastest first: kx, ky, ch, ocol, orow.
  - Ranges: kx,ky in 0..K-1; ch in 0..CH-1; ocol in 0..IMG_W-K; orow in 0..IMG_H-K.
  - Pixel address = ch*IMG_W*IMG_H + (orow+ky)*IMG_W + (ocol+kx). Weight address = ch*K*K + ky*K + kx.
- Flags:
  - out_first = all of kx,ky,ch at 0.
  - out_last_win = all of kx,ky,ch at their maxima.
  - out_last = out_last_win & ocol==IMG_W-K & orow==IMG_H-K.
- Beats per frame = (IMG_H-K+1)*(IMG_W-K+1)*CH*K*K.
- All address arithmetic is unsigned, using widths from $clog2 of the array sizes. No out-of-range address is ever generated.

Decomposition:
- Shared package wbmem_pkg: FSM state enum (IDLE, FETCH, EMIT, DONE), load_sel encodings, and localparam helpers for IMG_DEPTH=CH*IMG_W*IMG_H, WGT_DEPTH=CH*K*K and address widths.
- One natural sub-module: wbmem_sp_ram (parametrised DW/DEPTH, one write port, one registered read port, no reset on the array), instantiated twice for image and weights.

Test Plan:
Bench parameters: IMG_W=IMG_H=4, CH=2, K=3. Pixel at address a holds a; weight at address b holds 100+b.
1. Load 32 image beats and 18 weight beats with back-to-back valid -> img_loaded rises after beat 32, wgt_loaded after beat 18. start then yields 72 beats and exactly one done pulse.
2. With out_ready=1 throughout -> beat 0 is pix 0/wgt 100 with out_first. Beat 8 is pix 10/wgt 108. Beat 17 is pix 26/wgt 117 with out_last_win, row 0, col 0. Beat 71 is pix 31/wgt 117 with out_last, row 1, col 1.
3. Random out_ready stalls -> data and flags stable during stall, sequence identical to scenario 2, no beat dropped or duplicated.
4. start with only the image loaded -> busy stays 0, no out_valid. Completing the weight load then start -> normal frame.
5. 33rd image beat with value 0xAA -> address 0 overwritten, first beat out_pix=0xAA, img_loaded stays 1. in_ready=0 while busy; load beats during busy are not written.
6. rst asserted mid-frame (beat 40) -> all outputs 0 immediately, no done pulse, loaded flags 0, start ignored until both sets are reloaded.
